lzs_src_fetch_ctrl: RTL and testbench
=====================================

Name: lzs_src_fetch_ctrl

Overview:
- Sequences the encoder's 64-bit source FIFO (fifo_control + tpram, show-ahead) and emits a byte stream to the LZS encoder.
- Pops words with the active-low get strobe and unpacks each word little-endian into bytes under a valid/ready handshake.
- Counts the programmed byte total, drains padding up to the terminator word (last flag set), then signals end-of-stream.

Parameters:
- LZF_WIDTH, 20, width of byte-count input and internal remaining counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ce  in  1  clock enable; 0 freezes the block.
- start  in  1  one-cycle pulse in IDLE; samples fi_cnt.
- fi_cnt  in  LZF_WIDTH  total payload bytes for this stream.
- src_empty  in  1  source FIFO has no readable word.
- fi  in  64  FIFO head word, valid whenever src_empty=0.
- m_last  in  1  head word is the terminator.
- m_src_getn  out  1  active-low pop; the word is consumed at the rising edge while low.
- byte_o  out  8  output byte.
- byte_valid  out  1  byte_o valid.
- byte_ready  in  1  encoder accepts byte.
- byte_last  out  1  qualifies the final payload byte.
- busy  out  1  state not IDLE.
- done  out  1  one-cycle pulse at stream end.
- m_endn  out  1  active-low end pulse, coincident with done.
- err_short  out  1  sticky: terminator arrived before fi_cnt bytes; cleared by start.

Behaviour:
- Reset values: m_src_getn=1, byte_o=0, byte_valid=0, byte_last=0, busy=0, done=0, m_endn=1, err_short=0, state=IDLE.
- Reset is asynchronous and takes effect mid-operation. Nothing is flushed from the FIFO.
- States: IDLE, FETCH, SHIFT, DRAIN, DONE.
- ce=0 holds all state and registers, forces m_src_getn=1 and byte_valid=0, and ignores start. The same byte resumes when ce returns to 1.
- m_src_getn is combinational from the state and registered flags, low only when ce=1 and src_empty=0.
- IDLE:
  - on start, rem<=fi_cnt and err_short<=0.
  - if fi_cnt=0, go to DRAIN; else go to FETCH.
- FETCH:
  - if src_empty=0 and m_last=0: pop, word<=fi, idx<=0, go to SHIFT.
  - if src_empty=0 and m_last=1: pop, err_short<=1, go to DONE.
  - if src_empty=1: wait.
- SHIFT:
  - byte_o=word[8*idx+7 -: 8], so byte 0 is fi[7:0].
  - byte_valid=1; byte_last=(rem==1).
  - On valid&&ready: rem--, idx++.
  - If rem was 1, go to DRAIN.
  - Else if idx was 7, reload the next word:
    - zero-bubble reload when src_empty=0 and m_last=0: pop and load word in the same cycle, idx<=0, stay in SHIFT.
    - if the head is the terminator: pop, err_short<=1, go to DONE.
    - if src_empty=1: go to FETCH.
  - byte_o and byte_last must stay stable while valid&&!ready.
- DRAIN:
  - pop every available word.
  - non-terminator words (tail padding or extra words) are discarded.
  - on popping the terminator, go to DONE.
- DONE: done=1 and m_endn=0 for exactly one cycle, then IDLE.
- Throughput: 1 byte/cycle sustained when the FIFO is non-empty and ready=1. The first word costs one FETCH cycle.
- rem is unsigned LZF_WIDTH-bit and never decrements below 0. Maximum stream is 2^LZF_WIDTH-1 bytes.
- start outside IDLE is ignored.

Decomposition:
- Package lzs_src_pkg holds:
  - state enum (IDLE, FETCH, SHIFT, DRAIN, DONE);
  - WORD_BYTES=8;
  - IDX_W=3.
- One sub-module, lzs_byte_unpack: 64-bit word register, 3-bit index, load/advance controls, byte mux, and idx==7 flag.
- The FSM, remaining counter and flags stay in lzs_src_fetch_ctrl.

Test Plan:
- fi_cnt=16, FIFO = W0, W1, T(last), ready=1 → 16 bytes in order (W0[7:0] first, W1[63:56] last); byte_last on the 16th only; exactly 3 pops; W0→W1 with no gap cycle; single done/m_endn pulse.
- fi_cnt=13, same FIFO → 13 bytes, last byte W1[39:32] with byte_last; W1 bytes 5–7 never presented; T popped; done; err_short=0.
- fi_cnt=0, FIFO = T → 0 bytes; one pop; done within 3 cycles of start.
- fi_cnt=24, ready pattern 1,0,0,1 repeating, src_empty toggled every 5 cycles → 24 bytes, no loss or duplication; byte_o stable whenever valid&&!ready.
- fi_cnt=16, FIFO = W0, T → 8 bytes, no byte_last, err_short=1 and stays set until the next start, done pulse.
- ce=0 for 5 cycles at byte 3 of W0, then rst asserted mid-W1 → no pops and valid=0 while ce=0; byte 3 resumes; on rst all outputs take reset values before the next clock edge.

Source files
------------

// File: rtl/lzs_src_pkg.sv
// rtl/lzs_src_pkg.sv - shared constants and state encoding for the LZS source fetch controller
package lzs_src_pkg;

   localparam int WORD_BYTES = 8;
   localparam int IDX_W      = 3;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_FETCH = 3'd1;
   localparam state_t ST_SHIFT = 3'd2;
   localparam state_t ST_DRAIN = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/lzs_byte_unpack.sv
// rtl/lzs_byte_unpack.sv - holds one 64-bit source word and presents it little-endian, one byte at a time
module lzs_byte_unpack
   import lzs_src_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    advance,
   input  logic [8*WORD_BYTES-1:0] word_in,
   output logic [7:0]              byte_out,
   output logic                    idx_last
);

   logic [8*WORD_BYTES-1:0] word;
   logic [IDX_W-1:0]        idx;

   // load wins over advance so a zero-bubble reload restarts at byte 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word <= '0;
         idx  <= '0;
      end else if (load) begin
         word <= word_in;
         idx  <= '0;
      end else if (advance) begin
         idx  <= idx + 1'b1;
      end
   end

   assign byte_out = word[{idx, 3'b000} +: 8];
   assign idx_last = (idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/lzs_src_fetch_ctrl.sv
// rtl/lzs_src_fetch_ctrl.sv - pops the show-ahead source FIFO and streams the programmed byte count to the encoder
module lzs_src_fetch_ctrl
   import lzs_src_pkg::*;
#(
   parameter int LZF_WIDTH = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 start,
   input  logic [LZF_WIDTH-1:0] fi_cnt,
   input  logic                 src_empty,
   input  logic [63:0]          fi,
   input  logic                 m_last,
   output logic                 m_src_getn,
   output logic [7:0]           byte_o,
   output logic                 byte_valid,
   input  logic                 byte_ready,
   output logic                 byte_last,
   output logic                 busy,
   output logic                 done,
   output logic                 m_endn,
   output logic                 err_short
);

   localparam logic [LZF_WIDTH-1:0] REM_ONE = LZF_WIDTH'(1);

   state_t               state;
   logic [LZF_WIDTH-1:0] rem;
   logic                 head_ok;
   logic                 fire;
   logic                 rem_is_one;
   logic                 idx_last;
   logic                 pop;
   logic                 load;
   logic                 advance;

   assign head_ok    = ce && !src_empty;
   assign fire       = ce && (state == ST_SHIFT) && byte_ready;
   assign rem_is_one = (rem == REM_ONE);

   // the terminator is popped like any other word; it is simply never loaded
   always_comb begin
      pop  = 1'b0;
      load = 1'b0;
      case (state)
         ST_FETCH: begin
            pop  = head_ok;
            load = head_ok && !m_last;
         end
         ST_SHIFT: begin
            if (fire && !rem_is_one && idx_last) begin
               pop  = head_ok;
               load = head_ok && !m_last;
            end
         end
         ST_DRAIN: pop = head_ok;
         default: ;
      endcase
   end

   assign advance    = fire && !load;
   assign m_src_getn = !pop;
   assign byte_valid = ce && (state == ST_SHIFT);
   assign byte_last  = (state == ST_SHIFT) && rem_is_one;
   assign busy       = (state != ST_IDLE);
   assign done       = ce && (state == ST_DONE);
   assign m_endn     = !done;

   lzs_byte_unpack u_unpack (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .advance  (advance),
      .word_in  (fi),
      .byte_out (byte_o),
      .idx_last (idx_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         rem       <= '0;
         err_short <= 1'b0;
      end else if (ce) begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  rem       <= fi_cnt;
                  err_short <= 1'b0;
                  state     <= (fi_cnt == '0) ? ST_DRAIN : ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (!src_empty) begin
                  if (m_last) begin
                     err_short <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     state     <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               if (byte_ready) begin
                  if (rem != '0) rem <= rem - REM_ONE;
                  if (rem_is_one) begin
                     state <= ST_DRAIN;
                  end else if (idx_last) begin
                     if (src_empty) begin
                        state <= ST_FETCH;
                     end else if (m_last) begin
                        err_short <= 1'b1;
                        state     <= ST_DONE;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (!src_empty && m_last) state <= ST_DONE;
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lzs_src_fetch_ctrl.sv
// tb/tb_lzs_src_fetch_ctrl.sv - self-checking bench for lzs_src_fetch_ctrl against a queue-based FIFO/byte model
module tb_lzs_src_fetch_ctrl;

   localparam int W = 20;

   logic         clk = 1'b0;
   logic         rst;
   logic         ce;
   logic         start;
   logic [W-1:0] fi_cnt;
   logic         src_empty;
   logic [63:0]  fi;
   logic         m_last;
   logic         m_src_getn;
   logic [7:0]   byte_o;
   logic         byte_valid;
   logic         byte_ready;
   logic         byte_last;
   logic         busy;
   logic         done;
   logic         m_endn;
   logic         err_short;

   always #5 clk = ~clk;

   lzs_src_fetch_ctrl #(.LZF_WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .start      (start),
      .fi_cnt     (fi_cnt),
      .src_empty  (src_empty),
      .fi         (fi),
      .m_last     (m_last),
      .m_src_getn (m_src_getn),
      .byte_o     (byte_o),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_last  (byte_last),
      .busy       (busy),
      .done       (done),
      .m_endn     (m_endn),
      .err_short  (err_short)
   );

   typedef struct packed {
      logic        last;
      logic [63:0] data;
   } ent_t;

   ent_t       fifo_q[$];
   logic [7:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_mode, empty_mode;
   int acc, pops, dones, first_acc, last_acc, done_cyc, start_cyc;
   int exp_last_idx;
   logic       hold_v;
   logic [7:0] hold_b;
   logic       hold_l;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic force_empty;
      case (empty_mode)
         1:       force_empty = ((cyc / 5) % 2) == 1;
         2:       force_empty = ($urandom_range(0, 3) == 0);
         default: force_empty = 1'b0;
      endcase
      if (fifo_q.size() > 0 && !force_empty) begin
         src_empty = 1'b0;
         fi        = fifo_q[0].data;
         m_last    = fifo_q[0].last;
      end else begin
         src_empty = 1'b1;
         fi        = {$urandom, $urandom};
         m_last    = 1'($urandom);
      end
      case (ready_mode)
         1:       byte_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         2:       byte_ready = 1'($urandom);
         default: byte_ready = 1'b1;
      endcase
      #2;
      chk("m_endn_vs_done", m_endn, !done);
      if (!ce) begin
         chk("ce0_getn", m_src_getn, 1'b1);
         chk("ce0_valid", byte_valid, 1'b0);
      end
      if (byte_valid) begin
         if (hold_v) begin
            chk("stable_byte", byte_o, hold_b);
            chk("stable_last", byte_last, hold_l);
         end
         hold_v = !byte_ready;
         hold_b = byte_o;
         hold_l = byte_last;
         if (byte_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_byte", 1'b1, 1'b0);
            end else begin
               chk("byte", byte_o, exp_q.pop_front());
               chk("byte_last", byte_last, acc == exp_last_idx);
            end
            if (acc == 0) first_acc = cyc;
            last_acc = cyc;
            acc++;
         end
      end
      if (!m_src_getn) begin
         pops++;
         if (src_empty) chk("pop_when_empty", 1'b1, 1'b0);
         else void'(fifo_q.pop_front());
      end
      if (done) begin
         dones++;
         done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic load_stream(input int cnt, input int nwords, output int entries, output logic short_exp);
      logic [63:0] w;
      fifo_q.delete();
      exp_q.delete();
      for (int i = 0; i < nwords; i++) begin
         w = {$urandom, $urandom};
         fifo_q.push_back({1'b0, w});
         for (int b = 0; b < 8; b++)
            if (i * 8 + b < cnt) exp_q.push_back(w[8*b +: 8]);
      end
      fifo_q.push_back({1'b1, 32'($urandom), 32'($urandom)});
      short_exp    = (nwords * 8 < cnt);
      exp_last_idx = (short_exp || cnt == 0) ? -1 : cnt - 1;
      entries      = fifo_q.size();
      acc = 0; pops = 0; dones = 0; hold_v = 1'b0;
      first_acc = -1; last_acc = -1; done_cyc = -1;
   endtask

   task automatic kick(input int cnt);
      fi_cnt    = W'(cnt);
      start     = 1'b1;
      start_cyc = cyc;
      step();
      start     = 1'b0;
      fi_cnt    = W'($urandom);
      chk("err_clr_on_start", err_short, 1'b0);
   endtask

   task automatic run_stream(input int cnt, input int nwords, input int rmode, input int emode);
      int   entries;
      int   exp_n;
      logic short_exp;
      load_stream(cnt, nwords, entries, short_exp);
      exp_n      = exp_q.size();
      ready_mode = rmode;
      empty_mode = emode;
      kick(cnt);
      for (int k = 0; k < 3000 && dones == 0; k++) step();
      chk("done_seen", dones != 0, 1'b1);
      step();
      step();
      chk("byte_count", acc, exp_n);
      chk("bytes_left", exp_q.size(), 0);
      chk("pop_count", pops, entries);
      chk("done_pulses", dones, 1);
      chk("err_short", err_short, short_exp);
      chk("busy_after", busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; ce = 1'b1; start = 1'b0; fi_cnt = '0;
      src_empty = 1'b1; fi = '0; m_last = 1'b0; byte_ready = 1'b1;
      ready_mode = 0; empty_mode = 0; hold_v = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_getn", m_src_getn, 1'b1);
      chk("rst_byte", byte_o, 8'h00);
      chk("rst_valid", byte_valid, 1'b0);
      chk("rst_last", byte_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_endn", m_endn, 1'b1);
      chk("rst_err", err_short, 1'b0);
      rst = 1'b0;
      step();

      // two full words, no gaps between W0 and W1
      run_stream(16, 2, 0, 0);
      chk("no_gap_span", last_acc - first_acc, 15);

      // partial second word; trailing bytes of W1 never presented
      run_stream(13, 2, 0, 0);

      // empty payload: only the terminator
      run_stream(0, 0, 0, 0);
      chk("zero_done_latency", (done_cyc - start_cyc) <= 3, 1'b1);

      // back-pressure and FIFO starvation
      run_stream(24, 3, 1, 1);

      // terminator before the byte count is reached
      run_stream(16, 1, 0, 0);
      repeat (3) step();
      chk("err_sticky", err_short, 1'b1);

      for (int r = 0; r < 8; r++) begin
         int c;
         c = $urandom_range(1, 40);
         run_stream(c, $urandom_range(0, (c + 7) / 8 + 1), $urandom_range(0, 2), $urandom_range(0, 2));
      end

      // clock-enable freeze at byte 3, then asynchronous reset mid-W1
      begin
         int   entries;
         logic short_exp;
         load_stream(16, 2, entries, short_exp);
         ready_mode = 0;
         empty_mode = 0;
         kick(16);
         for (int k = 0; k < 50 && acc < 3; k++) step();
         chk("reached_byte3", acc, 3);
         ce = 1'b0;
         repeat (5) step();
         chk("ce0_no_bytes", acc, 3);
         chk("ce0_pops", pops, 1);
         ce = 1'b1;
         for (int k = 0; k < 50 && acc < 11; k++) step();
         chk("reached_mid_w1", acc, 11);
         #2;
         rst = 1'b1;
         #1;
         chk("arst_getn", m_src_getn, 1'b1);
         chk("arst_byte", byte_o, 8'h00);
         chk("arst_valid", byte_valid, 1'b0);
         chk("arst_last", byte_last, 1'b0);
         chk("arst_busy", busy, 1'b0);
         chk("arst_done", done, 1'b0);
         chk("arst_endn", m_endn, 1'b1);
         chk("arst_err", err_short, 1'b0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         cyc++;
      end

      // recovery after reset with a fresh FIFO image
      run_stream(8, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
